// File: rtl/sram_req_arbiter_if.sv
// sram_req_arbiter_if
//   One SRAM-like request/response port.
//   The requester side drives: req, wr, size, wstrb, addr, wdata.
//   The responder side drives: addr_ok, data_ok, rdata.
// Modports:
//   master - requester side (issues requests, receives handshakes and data)
//   slave  - responder side (accepts requests, returns handshakes and data)
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one SRAM-like memory port between the instruction requester
//   (inst) and the data requester (data). A grant is held (locked) on a
//   stalled request until the memory accepts it. A tag FIFO remembers the
//   source of every accepted request so that each response is steered back
//   to the requester that issued it. Responses return in acceptance order.
// Ports:
//   clk          - clock, rising edge
//   resetn       - asynchronous active-low reset
//   inst         - instruction requester port (slave modport)
//   data         - data requester port (slave modport)
//   mem          - downstream memory port (master modport)
//   err_spurious - sticky: a response arrived with no outstanding request
// Parameters:
//   DEPTH        - max accepted-but-unreturned requests (power of two, 2..16)
// Build option:
//   ARB_RR_EN    - when defined, unlocked arbitration is round-robin;
//                  otherwise data always beats instruction.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  sram_req_arbiter_if.slave         inst,
  sram_req_arbiter_if.slave         data,
  sram_req_arbiter_if.master        mem,
  output logic                      err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_t;

  lock_t            lock_src;
  logic [DEPTH-1:0] tag_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic full;
  logic empty;
  logic head;
  logic grant_valid;
  logic grant_data;
  logic accept;
  logic pop;

`ifdef ARB_RR_EN
  logic last_src;  // 1 = data was accepted most recently
`endif

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // Grant selection. A lock pins the grant to the stalled source even if the
  // other source now has priority. A full FIFO blocks every grant, even in a
  // cycle that also pops, so a response never races a new request for a slot.
  always_comb begin
    grant_valid = 1'b0;
    grant_data  = 1'b0;
    if (lock_src == LOCK_DATA) begin
      grant_valid = 1'b1;
      grant_data  = 1'b1;
    end else if (lock_src == LOCK_INST) begin
      grant_valid = 1'b1;
      grant_data  = 1'b0;
    end else if (inst.req || data.req) begin
      grant_valid = 1'b1;
`ifdef ARB_RR_EN
      grant_data  = data.req && (!inst.req || !last_src);
`else
      grant_data  = data.req;
`endif
    end
    if (full || !resetn) begin
      grant_valid = 1'b0;
    end
  end

  // Request path: forward the granted source's fields.
  assign mem.req   = grant_valid && (grant_data ? data.req : inst.req);
  assign mem.wr    = grant_data ? data.wr    : inst.wr;
  assign mem.size  = grant_data ? data.size  : inst.size;
  assign mem.wstrb = grant_data ? data.wstrb : inst.wstrb;
  assign mem.addr  = grant_data ? data.addr  : inst.addr;
  assign mem.wdata = grant_data ? data.wdata : inst.wdata;

  assign accept       = mem.req && mem.addr_ok;
  assign inst.addr_ok = accept && !grant_data;
  assign data.addr_ok = accept &&  grant_data;

  // Return path: a same-cycle push is not visible here, so a response never
  // matches a request accepted in the same cycle.
  assign pop          = resetn && mem.data_ok && !empty;
  assign inst.data_ok = pop && !head;
  assign data.data_ok = pop &&  head;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_src     <= LOCK_NONE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_spurious <= 1'b0;
`ifdef ARB_RR_EN
      last_src     <= 1'b0;
`endif
    end else begin
      // Lock on a presented-but-stalled request; a withdrawn request
      // (mem.req falls) and an acceptance both release it.
      if (accept) begin
        lock_src <= LOCK_NONE;
      end else if (mem.req) begin
        lock_src <= grant_data ? LOCK_DATA : LOCK_INST;
      end else begin
        lock_src <= LOCK_NONE;
      end

      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (mem.data_ok && empty) begin
        err_spurious <= 1'b1;
      end
`ifdef ARB_RR_EN
      if (accept) begin
        last_src <= grant_data;
      end
`endif
    end
  end

  // Tag storage carries no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[wr_ptr] <= grant_data;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter
//   Randomized scoreboard bench for sram_req_arbiter. The driver applies
//   requester and memory stimulus once per cycle, evaluates a behavioural
//   model (owner of a stalled request, queue of outstanding sources) and
//   pushes the expected request-path values and expected responses into
//   queues; a monitor on the falling edge pops and compares.
module tb_sram_req_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic err_spurious;

  sram_req_arbiter_if inst_if();
  sram_req_arbiter_if data_if();
  sram_req_arbiter_if mem_if();

  sram_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst         (inst_if),
    .data         (data_if),
    .mem          (mem_if),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mreq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    bit          iok;
    bit          dok;
    bit          err;
  } cyc_t;

  typedef struct {
    bit          src;    // 1 = data
    logic [31:0] rdata;
  } rsp_t;

  cyc_t cyc_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  int tags[$];      // sources of accepted, unreturned requests (1 inst, 2 data)
  int owner = 0;    // source whose presented request stalled last cycle
  bit last_src = 0; // most recently accepted source was data
  bit m_err = 0;

  bit hold_i = 0, hold_d = 0;
  bit acc_i = 0, acc_d = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Evaluate one cycle of the model against the stimulus currently applied.
  task automatic model_cycle(input bit in_reset);
    cyc_t e;
    int   g;
    bit   acc;
    e = '{default: '0};
    acc_i = 0;
    acc_d = 0;
    if (in_reset) begin
      tags.delete();
      owner = 0;
      last_src = 0;
      m_err = 0;
      cyc_q.push_back(e);
      return;
    end
    e.err = m_err;
    g = 0;
    if (owner != 0) begin
      g = owner;
    end else if (inst_if.req || data_if.req) begin
`ifdef ARB_RR_EN
      if (inst_if.req && data_if.req) g = last_src ? 1 : 2;
      else g = data_if.req ? 2 : 1;
`else
      g = data_if.req ? 2 : 1;
`endif
    end
    if (tags.size() == DEPTH) g = 0;
    e.mreq = (g == 1 && inst_if.req) || (g == 2 && data_if.req);
    if (g == 2) begin
      e.addr = data_if.addr; e.wdata = data_if.wdata; e.wr = data_if.wr;
      e.size = data_if.size; e.wstrb = data_if.wstrb;
    end else begin
      e.addr = inst_if.addr; e.wdata = inst_if.wdata; e.wr = inst_if.wr;
      e.size = inst_if.size; e.wstrb = inst_if.wstrb;
    end
    acc   = e.mreq && mem_if.addr_ok;
    e.iok = acc && g == 1;
    e.dok = acc && g == 2;
    // Responses see the outstanding list before this cycle's acceptance.
    if (mem_if.data_ok) begin
      if (tags.size() > 0) begin
        rsp_t r;
        r.src = (tags.pop_front() == 2);
        r.rdata = mem_if.rdata;
        rsp_q.push_back(r);
      end else begin
        m_err = 1;
      end
    end
    if (acc) begin
      tags.push_back(g);
      last_src = (g == 2);
      owner = 0;
    end else begin
      owner = e.mreq ? g : 0;
    end
    acc_i = e.iok;
    acc_d = e.dok;
    cyc_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    cyc_t e;
    rsp_t r;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("mem_req", {31'd0, mem_if.req}, {31'd0, e.mreq});
      if (e.mreq) begin
        chk("mem_addr", mem_if.addr, e.addr);
        chk("mem_wdata", mem_if.wdata, e.wdata);
        chk("mem_wr", {31'd0, mem_if.wr}, {31'd0, e.wr});
        chk("mem_size", {30'd0, mem_if.size}, {30'd0, e.size});
        chk("mem_wstrb", {28'd0, mem_if.wstrb}, {28'd0, e.wstrb});
      end
      chk("inst_addr_ok", {31'd0, inst_if.addr_ok}, {31'd0, e.iok});
      chk("data_addr_ok", {31'd0, data_if.addr_ok}, {31'd0, e.dok});
      chk("err_spurious", {31'd0, err_spurious}, {31'd0, e.err});
    end
    if (inst_if.data_ok || data_if.data_ok) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_data_ok", {30'd0, data_if.data_ok, inst_if.data_ok}, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_data_ok", {30'd0, data_if.data_ok, inst_if.data_ok},
            r.src ? 32'd2 : 32'd1);
        chk("rsp_rdata", r.src ? data_if.rdata : inst_if.rdata, r.rdata);
      end
    end else if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk("missing_data_ok", 32'd0, r.src ? 32'd2 : 32'd1);
    end
  end

  task automatic idle_inputs();
    inst_if.req = 0; data_if.req = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
  endtask

  initial begin
    inst_if.req = 1; inst_if.wr = 0; inst_if.size = 2; inst_if.wstrb = 0;
    inst_if.addr = 32'h1c000000; inst_if.wdata = 0;
    data_if.req = 1; data_if.wr = 1; data_if.size = 2; data_if.wstrb = 4'hf;
    data_if.addr = 32'h00001000; data_if.wdata = 32'h12345678;
    mem_if.addr_ok = 1; mem_if.data_ok = 1; mem_if.rdata = 32'hdeadbeef;
    resetn = 0;

    // Requests and responses presented during reset must be ignored.
    repeat (3) begin
      @(posedge clk); #1;
      model_cycle(1);
    end
    @(posedge clk); #1;
    resetn = 1;
    idle_inputs();
    model_cycle(0);

    // Randomized traffic; slow-response phases drive the FIFO to full.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit slow;
      @(posedge clk); #1;
      slow = ((cyc / 400) % 2) == 1;
      if (acc_i) hold_i = 0;
      if (acc_d) hold_d = 0;
      if (hold_i && $urandom_range(0, 15) == 0) hold_i = 0;
      if (hold_d && $urandom_range(0, 15) == 0) hold_d = 0;
      if (!hold_i && $urandom_range(0, 2) == 0) begin
        hold_i = 1;
        inst_if.addr = $urandom; inst_if.wdata = $urandom;
        inst_if.wr = 1'($urandom_range(0, 1)); inst_if.size = 2'($urandom_range(0, 3));
        inst_if.wstrb = 4'($urandom_range(0, 15));
      end
      if (!hold_d && $urandom_range(0, 2) == 0) begin
        hold_d = 1;
        data_if.addr = $urandom; data_if.wdata = $urandom;
        data_if.wr = 1'($urandom_range(0, 1)); data_if.size = 2'($urandom_range(0, 3));
        data_if.wstrb = 4'($urandom_range(0, 15));
      end
      inst_if.req = hold_i;
      data_if.req = hold_d;
      mem_if.addr_ok = 1'($urandom_range(0, 1));
      mem_if.data_ok = (tags.size() > 0) && ($urandom_range(0, slow ? 7 : 1) == 0);
      mem_if.rdata = $urandom;
      model_cycle(0);
    end

    // Drain all outstanding responses.
    hold_i = 0; hold_d = 0;
    for (int k = 0; k < 20 && tags.size() > 0; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      mem_if.data_ok = 1; mem_if.rdata = $urandom;
      model_cycle(0);
    end
    chk("drain_done", tags.size(), 0);

    // Unsolicited response: no data_ok, sets err_spurious.
    @(posedge clk); #1;
    idle_inputs();
    mem_if.data_ok = 1; mem_if.rdata = 32'hbad0bad0;
    model_cycle(0);
    repeat (2) begin
      @(posedge clk); #1;
      idle_inputs();
      model_cycle(0);
    end

    // Burst, then reset mid-burst with outstanding tags.
    repeat (3) begin
      @(posedge clk); #1;
      inst_if.req = 1; data_if.req = 1; mem_if.addr_ok = 1; mem_if.data_ok = 0;
      model_cycle(0);
    end
    @(posedge clk); #1;
    resetn = 0;
    mem_if.data_ok = 1;
    model_cycle(1);
    @(posedge clk); #1;
    model_cycle(1);
    @(posedge clk); #1;
    resetn = 1;
    idle_inputs();
    mem_if.data_ok = 1; mem_if.rdata = 32'h0badf00d;
    model_cycle(0);
    repeat (2) begin
      @(posedge clk); #1;
      idle_inputs();
      model_cycle(0);
    end

    @(posedge clk);
    @(posedge clk);
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter sharing one SRAM-like memory port between the fetch stage's instruction interface and the memory stage's data interface. It sits between the CPU pipeline and the SRAM-to-AXI bridge. It grants one request per cycle and locks the grant until `addr_ok`. It records the source of every accepted request in an in-order tag FIFO, so that each `data_ok`/`rdata` is routed back to the requester that issued it.

## Interface
Parameters:
- `DEPTH`, default 4: maximum accepted-but-unreturned requests; power of two, 2..16.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `inst_req`, `inst_wr`  input  1 each  instruction request and write flag; `inst_wr` is forwarded unchanged.
- `inst_size`  input  2  access size.
- `inst_wstrb`  input  4  byte write strobes.
- `inst_addr`, `inst_wdata`  input  32 each  address and write data.
- `inst_addr_ok`, `inst_data_ok`  output  1 each  request accepted / response returned.
- `inst_rdata`  output  32  read data.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`: inputs with the same widths as the `inst_` inputs, for the data requester.
- `data_addr_ok`, `data_data_ok`, `data_rdata`: outputs with the same widths as the `inst_` outputs, for the data requester.
- `mem_req`, `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata`  output  downstream request, same widths as the requester inputs.
- `mem_addr_ok`, `mem_data_ok`  input  1 each  downstream handshakes.
- `mem_rdata`  input  32  downstream read data.
- `err_spurious`  output  1  sticky flag: `mem_data_ok` arrived while the tag FIFO was empty.

## Operation
- **Downstream contract:**
  - A request is accepted in a cycle where `mem_req & mem_addr_ok`.
  - Every accepted request, read or write, returns exactly one `mem_data_ok`.
  - Responses return in acceptance order.
- **Grant selection (combinational) when unlocked:**
  - Data wins over instruction; instruction is granted only when `data_req`=0.
  - No grant if neither requester asserts `req`.
  - No grant if `count == DEPTH`. This holds even if a pop occurs in the same cycle.
- **Lock:** a 2-bit register `lock_src` ∈ {NONE, INST, DATA}.
  - Set to the granted source when `mem_req & ~mem_addr_ok`.
  - Cleared on acceptance.
  - Cleared if the locked requester drops `req`; its request is withdrawn and it gets no `addr_ok`.
  - While locked, the grant is forced to `lock_src`, even if the other requester has higher priority.
- **Request path:**
  - `mem_*` request fields are a mux of the granted source's fields.
  - `mem_req` = granted source's `req`.
  - The granted source's `addr_ok` = `mem_addr_ok & mem_req`.
  - The ungranted source's `addr_ok` = 0.
- **Tag FIFO:** `DEPTH` entries of 1 bit (0 = inst, 1 = data), with pointers and `count` of width log2(DEPTH)+1.
  - Push on acceptance; pop on `mem_data_ok`.
  - Simultaneous push and pop leaves `count` unchanged; both pointers advance modulo `DEPTH`.
- **Return path:**
  - `inst_data_ok` = `mem_data_ok & ~empty & head==0`.
  - `data_data_ok` = `mem_data_ok & ~empty & head==1`.
  - `mem_rdata` is fanned out to both `rdata` outputs unchanged; consumers qualify it with their own `data_ok`.
- **Spurious response:** `mem_data_ok` with an empty FIFO pulses neither `data_ok`, does not change `count`, and sets `err_spurious`.

## Timing
- Zero added latency: every output is combinational from current inputs and registered state.
- Registered state: `lock_src`, FIFO storage, pointers, `count`, `err_spurious`.
- Reset (asynchronous, `resetn`=0):
  - `lock_src`=NONE, `count`=0, pointers=0, `err_spurious`=0.
  - `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` are all forced to 0 while reset is asserted.
- Reset mid-transaction: all outstanding tags are discarded; responses arriving after release count as spurious.
- A request accepted in cycle N can receive its `data_ok` in cycle N+1 at the earliest, because a same-cycle response sees the pre-push FIFO state.
- Full FIFO: `mem_req`=0 in every cycle where `count==DEPTH`. Requests resume in the cycle after a pop brings `count` below `DEPTH`.

## Configuration
- `ARB_RR_EN` defined:
  - Unlocked arbitration is round-robin.
  - A 1-bit `last_src` register, reset to inst, updates on each acceptance.
  - When both sources request, the one not equal to `last_src` wins.
- `ARB_RR_EN` undefined: fixed data-over-instruction priority, and no `last_src` register exists.

## Test plan
- **Single read:**
  - Stimulus: `inst_req`=1, `addr`=0x1c000000, `mem_addr_ok`=1 in cycle 0; `mem_data_ok`=1 with `rdata`=0x02800c0c in cycle 2.
  - Required: `inst_addr_ok`=1 in cycle 0; `inst_data_ok`=1 and `inst_rdata`=0x02800c0c in cycle 2; `count` ends at 0.
- **Contention, default build:**
  - Stimulus: both `req`=1 with `mem_addr_ok`=1 for two cycles.
  - Required: data is granted in both cycles; `inst_addr_ok` stays 0.
- **Contention, `ARB_RR_EN` build:** same stimulus; required grants are data, then inst.
- **Lock:**
  - Stimulus: inst is granted with `mem_addr_ok`=0; `data_req` rises in the next cycle.
  - Required: `mem_addr` stays equal to `inst_addr` until `mem_addr_ok`=1; then the data request is granted in the following cycle.
- **Full:**
  - Stimulus: `DEPTH`=4; 4 data writes are accepted with no responses.
  - Required: `mem_req`=0 in the 5th cycle despite `data_req`=1. One `mem_data_ok` arrives, and the request is issued in the next cycle.
- **Ordering and spurious response:**
  - Stimulus: accept inst, data, inst; then return 3 responses followed by a 4th unsolicited one.
  - Required: responses route inst, data, inst; the 4th sets `err_spurious`=1 with no `data_ok` pulse.
- **Reset:** asserting `resetn`=0 mid-burst clears `count` and `err_spurious` immediately.
